// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants for the UART receive FIFO responder: register offsets,
// STATUS/CTRL bit positions, receiver state encoding and oversampling
// constants. No ports.
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    // Register offsets from the block base address
    localparam logic [31:0] RXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam logic [31:0] CTRL_OFS   = 32'h8;

    // STATUS bit positions
    localparam int unsigned ST_NONEMPTY_BIT  = 0;
    localparam int unsigned ST_FULL_BIT      = 1;
    localparam int unsigned ST_FRAME_ERR_BIT = 2;
    localparam int unsigned ST_OVERRUN_BIT   = 3;
    localparam int unsigned ST_COUNT_LSB     = 4;
    localparam int unsigned ST_COUNT_MSB     = 8;

    // CTRL bit positions (bits 2 and 3 are write-only strobes)
    localparam int unsigned CTRL_RX_EN_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned CTRL_CLR_ERR_BIT = 2;
    localparam int unsigned CTRL_FLUSH_BIT   = 3;

    // Oversampling: ticks per bit, and tick at which the start bit is checked
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_slave_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver with 16x oversampling.
// Ports:
//   sysclk        system clock
//   reset         asynchronous, active-low reset
//   rx_en_i       receiver enable; clearing it aborts any frame in progress
//   rx_i          asynchronous serial input, idle high
//   byte_valid_o  one-cycle pulse: byte_o holds a correctly framed byte
//   byte_o        last received byte
//   frame_err_o   one-cycle pulse: stop bit sampled low, byte discarded
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 65
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx_en_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [1:0]    sync_q;
    logic          line_prev_q;
    logic [DW-1:0] div_q;
    logic [3:0]    os_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          frame_err_q;
    rx_state_e     state_q;

    logic line_w;
    logic fall_w;
    logic tick_w;

    assign line_w = sync_q[1];
    assign fall_w = line_prev_q & ~line_w;
    // Tick generator only runs while a frame is in progress
    assign tick_w = (state_q != RX_IDLE) && (div_q == DW'(BAUD_DIV - 1));

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign frame_err_o  = frame_err_q;

    // Two-flop synchronizer plus edge-detect history, reset to idle level
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], rx_i};
            line_prev_q <= line_w;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_IDLE;
            div_q        <= '0;
            os_q         <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // Held at 0 in IDLE, so it is freshly reloaded on start detect
            if (state_q == RX_IDLE || tick_w) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DW'(1);
            end

            if (!rx_en_i) begin
                state_q <= RX_IDLE;
                os_q    <= '0;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        os_q <= '0;
                        if (fall_w) begin
                            state_q <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (tick_w) begin
                            if (os_q == 4'(MID_SAMPLE - 1)) begin
                                os_q <= '0;
                                if (!line_w) begin
                                    state_q   <= RX_DATA;
                                    bit_idx_q <= '0;
                                end else begin
                                    state_q <= RX_IDLE;
                                end
                            end else begin
                                os_q <= os_q + 4'd1;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick_w) begin
                            if (os_q == 4'(OVERSAMPLE - 1)) begin
                                os_q    <= '0;
                                shift_q <= {line_w, shift_q[7:1]};
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= RX_STOP;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 3'd1;
                                end
                            end else begin
                                os_q <= os_q + 4'd1;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (tick_w) begin
                            if (os_q == 4'(OVERSAMPLE - 1)) begin
                                os_q    <= '0;
                                state_q <= RX_IDLE;
                                if (line_w) begin
                                    byte_valid_q <= 1'b1;
                                    byte_q       <= shift_q;
                                end else begin
                                    frame_err_q <= 1'b1;
                                end
                            end else begin
                                os_q <= os_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_slave.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_slave
// Memory-mapped UART receiver with byte FIFO on the CPU data bus.
// Ports:
//   sysclk  system clock
//   reset   asynchronous, active-low reset
//   rd      bus read strobe (one cycle per load)
//   wr      bus write strobe (one cycle per store)
//   addr    bus byte address
//   wdata   bus write data
//   rdata   combinational read data; 0 unless rd=1 and addr in window
//   rx_in   asynchronous serial line, idle high
//   irqout  registered level interrupt
// Registers: +0 RXDATA (read pops), +4 STATUS, +8 CTRL.
// ---------------------------------------------------------------------------
module uart_rx_fifo_slave
    import uart_rx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h40000030,
    parameter int unsigned BAUD_DIV   = 65,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_in,
    output logic        irqout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic          rx_en_q;
    logic          irq_en_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          irq_q;
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          rx_valid_w;
    logic [7:0]    rx_byte_w;
    logic          rx_ferr_w;
    logic [AW:0]   count_w;
    logic          nonempty_w;
    logic          full_w;
    logic          sel_data_w;
    logic          sel_status_w;
    logic          sel_ctrl_w;
    logic          pop_w;
    logic          push_ok_w;
    logic          ctrl_wr_w;
    logic          flush_w;
    logic          clr_w;
    logic [31:0]   status_w;
    logic          unused_w;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .sysclk       (sysclk),
        .reset        (reset),
        .rx_en_i      (rx_en_q),
        .rx_i         (rx_in),
        .byte_valid_o (rx_valid_w),
        .byte_o       (rx_byte_w),
        .frame_err_o  (rx_ferr_w)
    );

    assign unused_w = ^wdata[31:4];

    assign count_w    = wptr_q - rptr_q;
    assign nonempty_w = (count_w != '0);
    assign full_w     = (count_w == (AW + 1)'(FIFO_DEPTH));

    assign sel_data_w   = (addr == BASE_ADDR + RXDATA_OFS);
    assign sel_status_w = (addr == BASE_ADDR + STATUS_OFS);
    assign sel_ctrl_w   = (addr == BASE_ADDR + CTRL_OFS);

    assign pop_w     = rd & sel_data_w & nonempty_w;
    assign ctrl_wr_w = wr & sel_ctrl_w;
    assign flush_w   = ctrl_wr_w & wdata[CTRL_FLUSH_BIT];
    assign clr_w     = ctrl_wr_w & wdata[CTRL_CLR_ERR_BIT];
    // A push into a full FIFO is still accepted when a pop frees a slot
    assign push_ok_w = rx_valid_w & (~full_w | pop_w);

    always_comb begin
        status_w = '0;
        status_w[ST_NONEMPTY_BIT]             = nonempty_w;
        status_w[ST_FULL_BIT]                 = full_w;
        status_w[ST_FRAME_ERR_BIT]            = frame_err_q;
        status_w[ST_OVERRUN_BIT]              = overrun_q;
        status_w[ST_COUNT_MSB:ST_COUNT_LSB]   = 5'(count_w);
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_data_w) begin
                rdata[7:0] = nonempty_w ? mem_q[rptr_q[AW-1:0]] : 8'h00;
            end else if (sel_status_w) begin
                rdata = status_w;
            end else if (sel_ctrl_w) begin
                rdata[CTRL_RX_EN_BIT]  = rx_en_q;
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
        end
    end

    assign irqout = irq_q;

    always_ff @(posedge sysclk) begin
        if (push_ok_w && !flush_w) begin
            mem_q[wptr_q[AW-1:0]] <= rx_byte_w;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rx_en_q     <= 1'b1;
            irq_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (flush_w) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push_ok_w) begin
                    wptr_q <= wptr_q + (AW + 1)'(1);
                end
                if (pop_w) begin
                    rptr_q <= rptr_q + (AW + 1)'(1);
                end
            end

            // New error events take priority over a clear strobe
            if (rx_ferr_w) begin
                frame_err_q <= 1'b1;
            end else if (clr_w) begin
                frame_err_q <= 1'b0;
            end

            if (rx_valid_w && full_w && !pop_w && !flush_w) begin
                overrun_q <= 1'b1;
            end else if (clr_w) begin
                overrun_q <= 1'b0;
            end

            if (ctrl_wr_w) begin
                rx_en_q  <= wdata[CTRL_RX_EN_BIT];
                irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
            end

            irq_q <= irq_en_q & (nonempty_w | frame_err_q | overrun_q);
        end
    end

endmodule
